// File: rtl/fft_frame_sched_if.sv
// rtl/fft_frame_sched_if.sv - sample, frame-buffer, FFT and analysis handshake bundle of fft_frame_sched
// ovf_cnt exists only when FFT_SCHED_OVF_CNT_EN is defined.
interface fft_frame_sched_if #(
  parameter int ADDR_W = 4
);
  logic              fir_valid;
  logic [15:0]       fir_d;
  logic              buf_we;
  logic              buf_bank;
  logic [ADDR_W-1:0] buf_addr;
  logic [15:0]       buf_wdata;
  logic              fft_start;
  logic              fft_bank;
  logic              fft_done;
  logic              fft_valid;
  logic              anl_start;
  logic              anl_done;
  logic              done;
  logic              ovf;
`ifdef FFT_SCHED_OVF_CNT_EN
  logic [7:0]        ovf_cnt;

  modport master (
    input  fir_valid, fir_d, fft_done, anl_done,
    output buf_we, buf_bank, buf_addr, buf_wdata, fft_start, fft_bank,
           fft_valid, anl_start, done, ovf, ovf_cnt
  );
  modport slave (
    output fir_valid, fir_d, fft_done, anl_done,
    input  buf_we, buf_bank, buf_addr, buf_wdata, fft_start, fft_bank,
           fft_valid, anl_start, done, ovf, ovf_cnt
  );
`else
  modport master (
    input  fir_valid, fir_d, fft_done, anl_done,
    output buf_we, buf_bank, buf_addr, buf_wdata, fft_start, fft_bank,
           fft_valid, anl_start, done, ovf
  );
  modport slave (
    output fir_valid, fir_d, fft_done, anl_done,
    input  buf_we, buf_bank, buf_addr, buf_wdata, fft_start, fft_bank,
           fft_valid, anl_start, done, ovf
  );
`endif
endinterface

// File: rtl/fft_frame_sched.sv
// rtl/fft_frame_sched.sv - FFT stage scheduler: ping-pong frame fill, FFT launch per frame, analysis hand-off
// Defining FFT_SCHED_OVF_CNT_EN adds the saturating drop counter ovf_cnt.
module fft_frame_sched #(
  parameter int FRAME_LEN  = 16,
  parameter int ADDR_W     = 4,
  parameter int NUM_FRAMES = 64,
  parameter int FCNT_W     = 7
) (
  input logic               clk,
  input logic               rst,
  fft_frame_sched_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_OUT,
    S_ANL,
    S_AWAIT,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic              wbank_q, wbank_d;
  logic              rbank_q, rbank_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [1:0]        full_q, full_d;
  logic              ovf_q, ovf_d;

  logic accept, we, drop;
  logic fft_start, fft_valid, anl_start, done_o;

  // A sample is only lost when the bank it would land in still awaits the FFT.
  assign accept = bus.fir_valid & (state_q != S_FIN);
  assign we     = accept & ~full_q[wbank_q];
  assign drop   = accept & full_q[wbank_q];

  assign bus.buf_we    = we;
  assign bus.buf_bank  = wbank_q;
  assign bus.buf_addr  = wcnt_q;
  assign bus.buf_wdata = bus.fir_d;
  assign bus.fft_start = fft_start;
  assign bus.fft_bank  = rbank_q;
  assign bus.fft_valid = fft_valid;
  assign bus.anl_start = anl_start;
  assign bus.done      = done_o;
  assign bus.ovf       = ovf_q;

  always_comb begin
    state_d   = state_q;
    wbank_d   = wbank_q;
    rbank_d   = rbank_q;
    wcnt_d    = wcnt_q;
    fcnt_d    = fcnt_q;
    full_d    = full_q;
    ovf_d     = ovf_q | drop;
    fft_start = 1'b0;
    fft_valid = 1'b0;
    anl_start = 1'b0;
    done_o    = 1'b0;

    if (we) begin
      if (wcnt_q == ADDR_W'(FRAME_LEN - 1)) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
        wcnt_d          = '0;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE:  if (full_q[rbank_q]) state_d = S_START;
      S_START: begin
        fft_start = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN:   if (bus.fft_done) state_d = S_OUT;
      S_OUT: begin
        // Writer never targets a full bank, so this clear cannot collide with a set.
        fft_valid       = 1'b1;
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
        fcnt_d          = fcnt_q + 1'b1;
        state_d         = (fcnt_q == FCNT_W'(NUM_FRAMES - 1)) ? S_ANL : S_IDLE;
      end
      S_ANL: begin
        anl_start = 1'b1;
        state_d   = S_AWAIT;
      end
      S_AWAIT: if (bus.anl_done) state_d = S_FIN;
      S_FIN:   done_o = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wcnt_q  <= '0;
      fcnt_q  <= '0;
      full_q  <= 2'b00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q  <= wcnt_d;
      fcnt_q  <= fcnt_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef FFT_SCHED_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  assign bus.ovf_cnt = ovf_cnt_q;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_cnt_q <= 8'd0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
// tb/tb_fft_frame_sched.sv - directed bench for fft_frame_sched against a timestamp-based frame model
// Also checks ovf_cnt when FFT_SCHED_OVF_CNT_EN is defined.
module tb_fft_frame_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_frame_sched_if #(.ADDR_W(4)) ifc ();

  fft_frame_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic man_done  = 1'b0;
  logic auto_done = 1'b0;
  logic auto_en   = 1'b0;
  int   auto_delay = 20;
  assign ifc.fft_done = man_done | auto_done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: write position, full banks, and the cycle each scheduled event must appear on.
  int m_widx, m_frames, m_drops, m_start_at, m_valid_at, m_anl_at, m_done_at;
  bit m_wbank, m_rbank, m_ovf, m_job, m_anl, m_fin;
  bit [1:0] m_full;
  bit fin_now, e_full, e_we;

  int n_start, n_valid, n_anl, last_start_cyc;
  int start_c [0:79];
  int valid_c [0:79];
  bit start_bank [0:79];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_widx = 0; m_frames = 0; m_drops = 0;
      m_start_at = -1; m_valid_at = -1; m_anl_at = -1; m_done_at = -1;
      m_wbank = 0; m_rbank = 0; m_ovf = 0; m_job = 0; m_anl = 0; m_fin = 0;
      m_full = 2'b00;
      n_start = 0; n_valid = 0; n_anl = 0; last_start_cyc = -1000;
    end else begin
      fin_now = m_fin && (cyc >= m_done_at);
      e_full  = m_full[m_wbank];
      e_we    = ifc.fir_valid && !e_full && !fin_now;
      chk("buf_we", ifc.buf_we, e_we);
      chk("buf_bank", ifc.buf_bank, m_wbank);
      chk("buf_addr", ifc.buf_addr, m_widx);
      if (e_we) chk("buf_wdata", ifc.buf_wdata, ifc.fir_d);
      chk("fft_start", ifc.fft_start, m_job && (cyc == m_start_at));
      chk("fft_valid", ifc.fft_valid, m_job && (cyc == m_valid_at));
      chk("anl_start", ifc.anl_start, m_anl && (cyc == m_anl_at));
      chk("done", ifc.done, fin_now);
      chk("ovf", ifc.ovf, m_ovf);
`ifdef FFT_SCHED_OVF_CNT_EN
      chk("ovf_cnt", ifc.ovf_cnt, m_drops);
`endif
      if (m_job && (cyc >= m_start_at)) chk("fft_bank", ifc.fft_bank, m_rbank);
      if (ifc.fft_valid)
        chk("set_clr_same_bank", ifc.buf_we && (ifc.buf_addr == 4'd15) && (ifc.buf_bank == ifc.fft_bank), 0);

      if (ifc.fft_start) begin
        if (n_start < 80) begin
          start_c[n_start] = cyc;
          start_bank[n_start] = ifc.fft_bank;
        end
        n_start++;
        last_start_cyc = cyc;
      end
      if (ifc.fft_valid) begin
        if (n_valid < 80) valid_c[n_valid] = cyc;
        n_valid++;
      end
      if (ifc.anl_start) n_anl++;

      // Advance the model to the next cycle.
      if (m_job && (cyc == m_valid_at)) begin
        m_full[m_rbank] = 0;
        m_rbank = !m_rbank;
        m_frames++;
        m_job = 0; m_valid_at = -1; m_start_at = -1;
        if (m_frames == 64) begin
          m_anl = 1;
          m_anl_at = cyc + 1;
        end
      end
      if (m_job && (m_valid_at < 0) && (cyc > m_start_at) && ifc.fft_done) m_valid_at = cyc + 1;
      if (m_anl && !m_fin && (cyc > m_anl_at) && ifc.anl_done) begin
        m_fin = 1;
        m_done_at = cyc + 1;
      end
      if (ifc.fir_valid && !fin_now) begin
        if (e_full) begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end else begin
          m_widx++;
          if (m_widx == 16) begin
            m_full[m_wbank] = 1;
            m_wbank = !m_wbank;
            m_widx = 0;
          end
        end
      end
      if (!m_job && !m_anl && m_full[m_rbank]) begin
        m_job = 1;
        m_start_at = cyc + 2;
      end
    end
    cyc++;
  end

  initial forever begin
    @(posedge clk); #1;
    auto_done = auto_en && (cyc == last_start_cyc + auto_delay);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; auto_en = 1'b0; man_done = 1'b0;
    ifc.fir_valid = 1'b0; ifc.fir_d = 16'h0; ifc.anl_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send(input int n, input logic [15:0] d0, input int gap, output int last);
    last = -1;
    for (int i = 0; i < n; i++) begin
      ifc.fir_valid = 1'b1;
      ifc.fir_d = d0 + 16'(i);
      last = cyc;
      tick();
      if (gap > 0) begin
        ifc.fir_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    ifc.fir_valid = 1'b0;
  endtask

  task automatic wait_start(input int n, input int lim);
    for (int k = 0; k < lim && n_start < n; k++) tick();
    chk("timeout_fft_start", n_start >= n, 1);
  endtask

  task automatic wait_valid(input int n, input int lim);
    for (int k = 0; k < lim && n_valid < n; k++) tick();
    chk("timeout_fft_valid", n_valid >= n, 1);
  endtask

  task automatic wait_anl(input int n, input int lim);
    for (int k = 0; k < lim && n_anl < n; k++) tick();
    chk("timeout_anl_start", n_anl >= n, 1);
  endtask

  int last_n;

  initial begin
    ifc.fir_valid = 1'b0; ifc.fir_d = 16'h0; ifc.anl_done = 1'b0;
    repeat (2) tick();
    chk("rst_buf_we", ifc.buf_we, 0);
    chk("rst_buf_bank", ifc.buf_bank, 0);
    chk("rst_buf_addr", ifc.buf_addr, 0);
    chk("rst_buf_wdata", ifc.buf_wdata, 0);
    chk("rst_fft_start", ifc.fft_start, 0);
    chk("rst_fft_bank", ifc.fft_bank, 0);
    chk("rst_fft_valid", ifc.fft_valid, 0);
    chk("rst_anl_start", ifc.anl_start, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_ovf", ifc.ovf, 0);
    rst = 1'b0;

    // Single frame, manual fft_done six cycles after launch.
    send(16, 16'h0001, 0, last_n);
    wait_start(1, 10);
    chk("t1_start_latency", start_c[0] - last_n, 2);
    chk("t1_start_bank", start_bank[0], 0);
    while (cyc < start_c[0] + 6) tick();
    man_done = 1'b1; tick(); man_done = 1'b0;
    wait_valid(1, 5);
    chk("t1_valid_latency", valid_c[0] - start_c[0], 7);
    repeat (5) tick();
    chk("t1_no_restart", n_start, 1);

    // Back-to-back frames, engine takes 40 cycles.
    do_reset();
    auto_delay = 40; auto_en = 1'b1;
    send(32, 16'h0100, 0, last_n);
    wait_valid(2, 200);
    chk("t2_restart_gap", start_c[1] - valid_c[0], 2);
    chk("t2_second_bank", start_bank[1], 1);

    // Both banks full with the engine stalled: 33rd sample is dropped.
    do_reset();
    send(32, 16'h0200, 0, last_n);
    ifc.fir_valid = 1'b1; ifc.fir_d = 16'h0033;
    @(negedge clk);
    chk("t3_drop_we", ifc.buf_we, 0);
    tick();
    ifc.fir_valid = 1'b0;
    chk("t3_ovf", ifc.ovf, 1);
`ifdef FFT_SCHED_OVF_CNT_EN
    chk("t3_ovf_cnt_1", ifc.ovf_cnt, 1);
    send(299, 16'h0300, 0, last_n);
    chk("t3_ovf_cnt_sat", ifc.ovf_cnt, 255);
`endif

    // Full run of 1024 paced samples.
    do_reset();
    auto_delay = 20; auto_en = 1'b1;
    send(1024, 16'h1000, 1, last_n);
    wait_anl(1, 200);
    chk("t4_frames", n_valid, 64);
    repeat (3) tick();
    ifc.anl_done = 1'b1; tick(); ifc.anl_done = 1'b0;
    chk("t4_done_next", ifc.done, 1);
    repeat (5) tick();
    chk("t4_done_held", ifc.done, 1);
    chk("t4_single_anl", n_anl, 1);
    ifc.fir_valid = 1'b1; ifc.fir_d = 16'hBEEF;
    @(negedge clk);
    chk("t4_fin_no_write", ifc.buf_we, 0);
    tick();
    ifc.fir_valid = 1'b0;
    chk("t4_fin_no_ovf", ifc.ovf, 0);

    // Asynchronous reset while frame 5 is in the FFT engine.
    do_reset();
    auto_delay = 20; auto_en = 1'b1;
    send(80, 16'h2000, 1, last_n);
    ifc.fir_d = 16'h0;
    wait_start(5, 20);
    repeat (3) tick();
    #2 rst = 1'b1; auto_en = 1'b0;
    #1;
    chk("t5_rst_fft_start", ifc.fft_start, 0);
    chk("t5_rst_fft_bank", ifc.fft_bank, 0);
    chk("t5_rst_fft_valid", ifc.fft_valid, 0);
    chk("t5_rst_buf_bank", ifc.buf_bank, 0);
    chk("t5_rst_buf_addr", ifc.buf_addr, 0);
    chk("t5_rst_done", ifc.done, 0);
    chk("t5_rst_anl", ifc.anl_start, 0);
    tick();
    rst = 1'b0;
    ifc.fir_valid = 1'b1; ifc.fir_d = 16'h0A0A;
    @(negedge clk);
    chk("t5_restart_we", ifc.buf_we, 1);
    chk("t5_restart_bank", ifc.buf_bank, 0);
    chk("t5_restart_addr", ifc.buf_addr, 0);
    tick();
    send(15, 16'h0A0B, 0, last_n);
    wait_start(1, 10);
    chk("t5_restart_latency", start_c[0] - last_n, 2);

    // Stray completion pulses in IDLE are ignored.
    do_reset();
    man_done = 1'b1; ifc.anl_done = 1'b1;
    tick();
    man_done = 1'b0; ifc.anl_done = 1'b0;
    repeat (3) tick();
    chk("t6_no_valid", n_valid, 0);
    chk("t6_no_start", n_start, 0);
    chk("t6_no_done", ifc.done, 0);
    send(16, 16'h0050, 0, last_n);
    wait_start(1, 10);
    chk("t6_still_idle_ok", start_c[0] - last_n, 2);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
